// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: resolves load-use, branch, mul/div and memory-miss
// hazards into per-stage load/flush enables, and counts PC-hold cycles.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic [5:0]  ID_Op,
   input  logic        Branch_Taken,
   input  logic        MulDiv_Start,
   input  logic        MulDiv_Done,
   input  logic        IMem_Ready,
   input  logic        MEM_Access,
   input  logic        DMem_Ready,
   output logic        PC_WriteEn,
   output logic        IFID_WriteEn,
   output logic        IFID_Flush,
   output logic        IDEX_WriteEn,
   output logic        IDEX_Flush,
   output logic        EXMEM_WriteEn,
   output logic        EXMEM_Flush,
   output logic        IMem_Abort,
   output logic [15:0] Stall_Cnt
);

   // Opcodes whose rt field is a destination, so an rt match is not a true dependency.
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpXori = 6'b001110;

   typedef enum logic [1:0] {StRun, StIMiss, StMdWait, StDMiss} stateT;

   stateT       stateQ, stateD;
   logic [15:0] stallCntQ;
   logic        loadUse, dFreeze, mFreeze;

   always_comb begin
      loadUse = EX_MemRead &&
                ((EX_rt == ID_rs) || ((EX_rt == ID_rt) && (ID_Op != OpLw) && (ID_Op != OpXori)));
      dFreeze = !DMem_Ready && (MEM_Access || (stateQ == StDMiss));
      mFreeze = !MulDiv_Done && (MulDiv_Start || (stateQ == StMdWait));
   end

   always_comb begin
      PC_WriteEn    = 1'b1;
      IFID_WriteEn  = 1'b1;
      IFID_Flush    = 1'b0;
      IDEX_WriteEn  = 1'b1;
      IDEX_Flush    = 1'b0;
      EXMEM_WriteEn = 1'b1;
      EXMEM_Flush   = 1'b0;
      IMem_Abort    = 1'b0;
      if (rst) begin
         PC_WriteEn    = 1'b0;
         IFID_WriteEn  = 1'b0;
         IFID_Flush    = 1'b1;
         IDEX_WriteEn  = 1'b0;
         IDEX_Flush    = 1'b1;
         EXMEM_WriteEn = 1'b0;
         EXMEM_Flush   = 1'b1;
      end else if (dFreeze) begin
         // Whole pipe holds; a taken branch stays in EX until release.
         PC_WriteEn    = 1'b0;
         IFID_WriteEn  = 1'b0;
         IDEX_WriteEn  = 1'b0;
         EXMEM_WriteEn = 1'b0;
      end else if (mFreeze) begin
         PC_WriteEn    = 1'b0;
         IFID_WriteEn  = 1'b0;
         IDEX_WriteEn  = 1'b0;
         EXMEM_Flush   = 1'b1;
      end else if (Branch_Taken) begin
         IFID_Flush    = 1'b1;
         IDEX_Flush    = 1'b1;
         IMem_Abort    = !IMem_Ready;
      end else if (loadUse) begin
         PC_WriteEn    = 1'b0;
         IFID_WriteEn  = 1'b0;
         IDEX_Flush    = 1'b1;
      end else if (!IMem_Ready) begin
         PC_WriteEn    = 1'b0;
         IFID_Flush    = 1'b1;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StRun, StIMiss: begin
            if (dFreeze)                           stateD = StDMiss;
            else if (mFreeze)                      stateD = StMdWait;
            else if (!IMem_Ready && !Branch_Taken) stateD = StIMiss;
            else                                   stateD = StRun;
         end
         StMdWait: if (MulDiv_Done) stateD = StRun;
         StDMiss:  if (DMem_Ready)  stateD = StRun;
         default:                   stateD = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ    <= StRun;
         stallCntQ <= '0;
      end else begin
         stateQ <= stateD;
         if (!PC_WriteEn && (stallCntQ != 16'hFFFF)) stallCntQ <= stallCntQ + 16'd1;
      end
   end

   assign Stall_Cnt = stallCntQ;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued per step and
// compared against the DUT mid-cycle.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        EX_MemRead;
   logic [4:0]  EX_rt, ID_rs, ID_rt;
   logic [5:0]  ID_Op;
   logic        Branch_Taken, MulDiv_Start, MulDiv_Done, IMem_Ready, MEM_Access, DMem_Ready;
   logic        PC_WriteEn, IFID_WriteEn, IFID_Flush, IDEX_WriteEn, IDEX_Flush;
   logic        EXMEM_WriteEn, EXMEM_Flush, IMem_Abort;
   logic [15:0] Stall_Cnt;
   logic [7:0]  outVec;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .ID_rs(ID_rs),
      .ID_rt(ID_rt), .ID_Op(ID_Op), .Branch_Taken(Branch_Taken), .MulDiv_Start(MulDiv_Start),
      .MulDiv_Done(MulDiv_Done), .IMem_Ready(IMem_Ready), .MEM_Access(MEM_Access),
      .DMem_Ready(DMem_Ready), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
      .IFID_Flush(IFID_Flush), .IDEX_WriteEn(IDEX_WriteEn), .IDEX_Flush(IDEX_Flush),
      .EXMEM_WriteEn(EXMEM_WriteEn), .EXMEM_Flush(EXMEM_Flush), .IMem_Abort(IMem_Abort),
      .Stall_Cnt(Stall_Cnt)
   );

   assign outVec = {PC_WriteEn, IFID_WriteEn, IFID_Flush, IDEX_WriteEn,
                    IDEX_Flush, EXMEM_WriteEn, EXMEM_Flush, IMem_Abort};

   // {PC_WE, IFID_WE, IFID_FL, IDEX_WE, IDEX_FL, EXMEM_WE, EXMEM_FL, ABORT}
   localparam logic [7:0] Base = 8'b1101_0100;
   localparam logic [7:0] Rstv = 8'b0010_1010;
   localparam logic [7:0] Dfrz = 8'b0000_0000;
   localparam logic [7:0] Mfrz = 8'b0000_0110;
   localparam logic [7:0] Br   = 8'b1111_1100;
   localparam logic [7:0] Brab = 8'b1111_1101;
   localparam logic [7:0] Lu   = 8'b0001_1100;
   localparam logic [7:0] Im   = 8'b0111_0100;

   typedef struct {
      string       tag;
      logic [7:0]  ctl;
      logic [15:0] cnt;
   } expT;

   expT sb[$];
   int  nChecks = 0;
   int  nPass   = 0;

   task automatic idle();
      EX_MemRead = 1'b0; EX_rt = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0; ID_Op = 6'd0;
      Branch_Taken = 1'b0; MulDiv_Start = 1'b0; MulDiv_Done = 1'b0;
      IMem_Ready = 1'b1; MEM_Access = 1'b0; DMem_Ready = 1'b1;
   endtask

   task automatic doReset();
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Called at posedge+1 with inputs applied; samples at posedge+4, then crosses one edge.
   task automatic step(input string tag, input logic [7:0] ctl, input logic [15:0] cnt);
      expT e;
      sb.push_back('{tag, ctl, cnt});
      #3;
      e = sb.pop_front();
      nChecks++;
      assert (outVec === e.ctl) nPass++;
      else $error("FAIL %s ctl observed=%b expected=%b", e.tag, outVec, e.ctl);
      nChecks++;
      assert (Stall_Cnt === e.cnt) nPass++;
      else $error("FAIL %s Stall_Cnt observed=%h expected=%h", e.tag, Stall_Cnt, e.cnt);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $fatal(1, "FAIL watchdog: simulation did not complete");
   end

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      step("reset_hold", Rstv, 16'd0);
      rst = 1'b0;
      step("post_reset", Base, 16'd0);

      // Load-use on rs
      EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_rt = 5'd9;
      step("loaduse_rs", Lu, 16'd0);
      idle();
      step("loaduse_done", Base, 16'd1);

      // rt match only counts when the ID instruction reads rt
      EX_MemRead = 1'b1; EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3; ID_Op = 6'b100011;
      step("rt_lw_nostall", Base, 16'd1);
      ID_Op = 6'b001110;
      step("rt_op0e_nostall", Base, 16'd1);
      ID_Op = 6'b000000;
      step("rt_rtype_stall", Lu, 16'd1);
      idle();
      step("rt_done", Base, 16'd2);

      EX_MemRead = 1'b1; EX_rt = 5'd4; ID_rs = 5'd4; Branch_Taken = 1'b1;
      step("branch_over_lu", Br, 16'd2);
      idle();
      step("branch_after", Base, 16'd2);

      // Multi-cycle mul/div, Done on the fourth cycle
      doReset();
      MulDiv_Start = 1'b1;
      step("md_start", Mfrz, 16'd0);
      MulDiv_Start = 1'b0;
      step("md_wait2", Mfrz, 16'd1);
      step("md_wait3", Mfrz, 16'd2);
      MulDiv_Done = 1'b1;
      step("md_done", Base, 16'd3);
      MulDiv_Done = 1'b0;
      step("md_after", Base, 16'd3);
      MulDiv_Start = 1'b1; MulDiv_Done = 1'b1;
      step("md_start_done", Base, 16'd3);
      idle();
      step("md_start_done_next", Base, 16'd3);

      // Data miss with a pending branch held in EX
      doReset();
      MEM_Access = 1'b1; DMem_Ready = 1'b0; Branch_Taken = 1'b1;
      for (int i = 0; i < 5; i++) step($sformatf("dfrz_br%0d", i), Dfrz, 16'(i));
      DMem_Ready = 1'b1;
      step("dfrz_release_br", Br, 16'd5);
      idle();
      step("dfrz_after", Base, 16'd5);

      // DMISS holds without MEM_Access; release cycle falls through to load-use
      doReset();
      MEM_Access = 1'b1; DMem_Ready = 1'b0;
      step("dmiss_enter", Dfrz, 16'd0);
      MEM_Access = 1'b0;
      step("dmiss_state", Dfrz, 16'd1);
      DMem_Ready = 1'b1; EX_MemRead = 1'b1; EX_rt = 5'd6; ID_rs = 5'd6;
      step("dmiss_release_lu", Lu, 16'd2);
      idle();
      step("dmiss_after", Base, 16'd3);
      MEM_Access = 1'b1; DMem_Ready = 1'b0; MulDiv_Start = 1'b1;
      step("dfrz_over_md", Dfrz, 16'd3);
      idle();
      step("dfrz_over_md_rel", Base, 16'd4);

      // Fetch miss then taken branch aborts the fetch
      doReset();
      IMem_Ready = 1'b0;
      step("imiss1", Im, 16'd0);
      step("imiss2", Im, 16'd1);
      Branch_Taken = 1'b1;
      step("imiss_branch_abort", Brab, 16'd2);
      idle();
      step("imiss_after", Base, 16'd2);
      IMem_Ready = 1'b0;
      step("imiss_md1", Im, 16'd2);
      MulDiv_Start = 1'b1;
      step("imiss_md_start", Mfrz, 16'd3);
      MulDiv_Start = 1'b0; IMem_Ready = 1'b1;
      step("imiss_md_wait", Mfrz, 16'd4);
      MulDiv_Done = 1'b1;
      step("imiss_md_done", Base, 16'd5);

      // Saturation, then reset from inside MDWAIT
      doReset();
      IMem_Ready = 1'b0;
      repeat (65534) @(posedge clk);
      #1;
      step("sat_fffe", Im, 16'hFFFE);
      step("sat_ffff0", Im, 16'hFFFF);
      step("sat_ffff1", Im, 16'hFFFF);
      step("sat_ffff2", Im, 16'hFFFF);
      idle();
      MulDiv_Start = 1'b1;
      step("md_pre_rst", Mfrz, 16'hFFFF);
      MulDiv_Start = 1'b0;
      step("md_mid_rst", Mfrz, 16'hFFFF);
      rst = 1'b1;
      step("rst_in_md", Rstv, 16'hFFFF);
      rst = 1'b0;
      step("rst_md_after", Base, 16'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and rst, with rst sampled only on the clk rising edge.
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- EX_MemRead  in  1  EX-stage instruction is a load
- EX_rt  in  5  EX-stage rt
- ID_rs  in  5  ID-stage rs
- ID_rt  in  5  ID-stage rt
- ID_Op  in  6  ID-stage opcode
- Branch_Taken  in  1  taken branch/jump resolved in EX
- MulDiv_Start  in  1  multi-cycle mul/div occupies EX
- MulDiv_Done  in  1  mul/div result valid this cycle
- IMem_Ready  in  1  fetch data valid this cycle
- MEM_Access  in  1  MEM-stage load/store active
- DMem_Ready  in  1  data memory access completes this cycle
- PC_WriteEn  out  1  PC load enable
- IFID_WriteEn  out  1  IF/ID load enable
- IFID_Flush  out  1  IF/ID loads bubble
- IDEX_WriteEn  out  1  ID/EX load enable
- IDEX_Flush  out  1  ID/EX loads bubble
- EXMEM_WriteEn  out  1  EX/MEM load enable
- EXMEM_Flush  out  1  EX/MEM loads bubble
- IMem_Abort  out  1  cancel outstanding fetch
- Stall_Cnt  out  16  saturating count of PC-hold cycles

Function
REQ-003 The FSM SHALL have four states: RUN, IMISS, MDWAIT and DMISS.
REQ-004 Outputs other than Stall_Cnt SHALL be combinational from the state and the inputs, with zero-cycle latency.
REQ-005 Baseline outputs SHALL be: all WriteEn=1, all Flush=0, IMem_Abort=0.
REQ-006 LoadUse SHALL be defined as EX_MemRead AND (EX_rt==ID_rs OR (EX_rt==ID_rt AND ID_Op!=6'b100011 AND ID_Op!=6'b001110)).
REQ-007 Control resolution SHALL apply this priority, highest first:
- DFreeze = (MEM_Access AND !DMem_Ready) OR (state==DMISS AND !DMem_Ready): all four WriteEn=0, all Flush=0.
- MFreeze = (MulDiv_Start OR state==MDWAIT) AND !MulDiv_Done: PC_WriteEn=IFID_WriteEn=IDEX_WriteEn=0, EXMEM_Flush=1.
- Branch_Taken: PC_WriteEn=1, IFID_Flush=1, IDEX_Flush=1, LoadUse ignored; additionally IMem_Abort=1 when IMem_Ready=0.
- LoadUse: PC_WriteEn=0, IFID_WriteEn=0, IDEX_Flush=1, IFID_Flush=0.
- !IMem_Ready: PC_WriteEn=0, IFID_Flush=1, downstream advances.
REQ-008 Transitions from RUN SHALL be: DFreeze->DMISS; else MFreeze->MDWAIT; else (!IMem_Ready AND !Branch_Taken)->IMISS; else RUN.
REQ-009 DMISS SHALL remain while DMem_Ready=0 and SHALL go to RUN on the DMem_Ready=1 cycle; that cycle SHALL resolve via the lower priority rows.
REQ-010 MDWAIT SHALL remain until MulDiv_Done=1, then go to RUN; the Done cycle SHALL release all enables.
REQ-011 IMISS SHALL go to RUN when IMem_Ready=1 or Branch_Taken=1; DFreeze or MFreeze in IMISS SHALL take DMISS or MDWAIT respectively.
REQ-012 MulDiv_Start and MulDiv_Done asserted together SHALL cause no stall and no MDWAIT entry.
REQ-013 Branch_Taken during DFreeze SHALL be ignored; the branch stays frozen in EX and applies on the release cycle.
REQ-014 Stall_Cnt SHALL increment by 1 on each clk edge where rst=0 and PC_WriteEn=0, and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-015 With rst=1 at a clk edge, the state SHALL become RUN and Stall_Cnt SHALL become 0, including mid-DMISS and mid-MDWAIT.
REQ-016 While rst=1, the outputs SHALL be: all WriteEn=0, all Flush=1, IMem_Abort=0.
REQ-017 In the first cycle after rst deasserts, the state SHALL be RUN and Stall_Cnt SHALL be 0.

Verification
REQ-018 EX_MemRead=1, EX_rt=5, ID_rs=5 -> one cycle of PC_WriteEn=0, IFID_WriteEn=0, IDEX_Flush=1; Stall_Cnt=1.
REQ-019 EX_rt=ID_rt=7, ID_Op=6'b100011, ID_rs=3, EX_MemRead=1 -> no stall; repeated with ID_Op=6'b000000 -> stall.
REQ-020 MulDiv_Start=1, then Done on cycle 4 -> MDWAIT for 3 cycles with EXMEM_Flush=1; release on cycle 4; Stall_Cnt=3.
REQ-021 MEM_Access=1, DMem_Ready=0 for 5 cycles while Branch_Taken=1 -> all enables 0 for 5 cycles; the branch flush (IFID_Flush=IDEX_Flush=1) occurs on the release cycle.
REQ-022 IMem_Ready=0 for 2 cycles, then Branch_Taken=1 -> IMem_Abort=1 and PC_WriteEn=1 that cycle; next state RUN.
REQ-023 Preload Stall_Cnt to 16'hFFFE and hold a stall for 4 cycles -> Stall_Cnt=16'hFFFF; rst during MDWAIT -> RUN and Stall_Cnt=0 on the next cycle.
